// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg: shared state encoding, parity codes and width helper      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   // Counter width for a range of n values; a single-value range still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_parity.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_parity: parity slot value for the latched transmit word        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module uart_parity
   import uart_pkg::*;
#(
   parameter int         DWIDTH = 8,
   parameter logic [1:0] PARTYP = 2'b00
) (
   input  logic [DWIDTH-1:0] data,
   output logic              parity_out
);

   logic xor_all;

   assign xor_all = ^data;

   // Odd parity makes the total count of ones odd; modes 00/11 send a constant 1.
   always_comb begin
      parity_out = 1'b1;
      case (PARTYP)
         PAR_ODD:  parity_out = ~xor_all;
         PAR_EVEN: parity_out = xor_all;
         default:  parity_out = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_ctrl: UART transmit sequencer (start, data LSB-first,       |
// | parity slot, stop) with valid/ready word intake. Revision: 1.0      |
// +--------------------------------------------------------------------+
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int         DWIDTH       = 8,
   parameter logic [1:0] PARTYP       = 2'b00,
   parameter int         CLKS_PER_BIT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [DWIDTH-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int BW  = clog2_min1(CLKS_PER_BIT);
   localparam int IW  = clog2_min1(DWIDTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BIT_LAST  = IW'(DWIDTH - 1);

   tx_state_t         state, state_n;
   logic [BW-1:0]     baud_cnt, baud_n;
   logic [IW-1:0]     bit_idx, bit_n;
   logic [DWIDTH-1:0] data_q, data_n;
   logic              out_n, done_n;
   logic              bit_end;
   logic              parity_bit;

   uart_parity #(
      .DWIDTH (DWIDTH),
      .PARTYP (PARTYP)
   ) u_parity (
      .data       (data_q),
      .parity_out (parity_bit)
   );

   assign tx_ready = (state == IDLE);
   assign tx_busy  = (state != IDLE);
   assign bit_end  = (baud_cnt == BAUD_LAST);

   always_comb begin
      state_n = state;
      baud_n  = bit_end ? '0 : baud_cnt + BW'(1);
      bit_n   = bit_idx;
      data_n  = data_q;
      case (state)
         IDLE: begin
            baud_n = '0;
            bit_n  = '0;
            if (tx_valid) begin
               state_n = START;
               data_n  = tx_data;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               bit_n   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == BIT_LAST) begin
                  state_n = PARITY;
               end else begin
                  bit_n = bit_idx + IW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) state_n = STOP;
         end
         STOP: begin
            if (bit_end) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Line level and done pulse are registered, so they follow the upcoming state.
      out_n = 1'b1;
      case (state_n)
         IDLE:    out_n = 1'b1;
         START:   out_n = 1'b0;
         DATA:    out_n = data_q[bit_n];
         PARITY:  out_n = parity_bit;
         STOP:    out_n = 1'b1;
         default: out_n = 1'b1;
      endcase
      done_n = (state_n == STOP) && (baud_n == BAUD_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         data_q   <= '0;
         tx_out   <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_n;
         data_q   <= data_n;
         tx_out   <= out_n;
         tx_done  <= done_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx_ctrl: four parameterisations against a frame-level model |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] valid, line, done, busy, ready;
   logic [7:0] d0, d1, d2;
   logic [4:0] d3;
   int         compared   = 0;
   int         mismatched = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.DWIDTH(8), .PARTYP(2'b01), .CLKS_PER_BIT(4)) u_odd (
      .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(d0), .tx_ready(ready[0]),
      .tx_out(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));
   uart_tx_ctrl #(.DWIDTH(8), .PARTYP(2'b10), .CLKS_PER_BIT(4)) u_even (
      .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(d1), .tx_ready(ready[1]),
      .tx_out(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));
   uart_tx_ctrl #(.DWIDTH(8), .PARTYP(2'b00), .CLKS_PER_BIT(4)) u_none (
      .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(d2), .tx_ready(ready[2]),
      .tx_out(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));
   uart_tx_ctrl #(.DWIDTH(5), .PARTYP(2'b01), .CLKS_PER_BIT(1)) u_small (
      .clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_data(d3), .tx_ready(ready[3]),
      .tx_out(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

   function automatic int dw_of(input int u);
      return (u == 3) ? 5 : 8;
   endfunction

   function automatic int cpb_of(input int u);
      return (u == 3) ? 1 : 4;
   endfunction

   function automatic int par_of(input int u);
      case (u)
         0: return 1;
         1: return 2;
         3: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic logic model_parity(input int u, input logic [31:0] w);
      int ones = 0;
      for (int i = 0; i < dw_of(u); i++) ones += int'(w[i]);
      case (par_of(u))
         1: return (ones % 2 == 0);
         2: return (ones % 2 == 1);
         default: return 1'b1;
      endcase
   endfunction

   // Frame as a list of slots, each CLKS_PER_BIT long; cycle 1 is the first after acceptance.
   function automatic logic model_line(input int u, input logic [31:0] w, input int k);
      int dw   = dw_of(u);
      int cpb  = cpb_of(u);
      int slot;
      if (k < 1 || k > (dw + 3) * cpb) return 1'b1;
      slot = (k - 1) / cpb;
      if (slot == 0) return 1'b0;
      if (slot <= dw) return w[slot-1];
      if (slot == dw + 1) return model_parity(u, w);
      return 1'b1;
   endfunction

   task automatic set_word(input int u, input logic [31:0] w);
      case (u)
         0: d0 = w[7:0];
         1: d1 = w[7:0];
         2: d2 = w[7:0];
         default: d3 = w[4:0];
      endcase
   endtask

   // Checks cycles 1..L+1 of a frame accepted at the previous posedge.
   task automatic check_frame(input int u, input logic [31:0] w, input bit hold,
                              input logic [31:0] w2, output logic par_seen);
      int L  = (dw_of(u) + 3) * cpb_of(u);
      int ps = (dw_of(u) + 1) * cpb_of(u) + 1;
      logic [3:0] exp_v, act_v;
      par_seen = 1'bx;
      for (int k = 1; k <= L + 1; k++) begin
         @(negedge clk);
         exp_v = {model_line(u, w, k), (k == L), (k <= L), (k > L)};
         act_v = {line[u], done[u], busy[u], ready[u]};
         compared++;
         if (act_v !== exp_v) begin
            mismatched++;
            $display("FAIL frame u%0d word=%h cycle %0d: {line,done,busy,ready} got %b want %b",
                     u, w, k, act_v, exp_v);
         end
         if (k == ps) par_seen = line[u];
         if (!hold) valid[u] = 1'b0;
         else if (k < L) set_word(u, $urandom);
         else set_word(u, w2);
      end
   endtask

   task automatic send(input int u, input logic [31:0] w, input bit hold,
                       input logic [31:0] w2, output logic par_seen);
      int n = 0;
      par_seen = 1'bx;
      @(negedge clk);
      while (!ready[u] && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!ready[u]) begin
         compared++;
         mismatched++;
         $display("FAIL ready_timeout u%0d: ready got %b want 1", u, ready[u]);
         return;
      end
      valid[u] = 1'b1;
      set_word(u, w);
      @(posedge clk);
      check_frame(u, w, hold, w2, par_seen);
   endtask

   task automatic check_idle(input string tag);
      compared++;
      if (line !== 4'hF || done !== 4'h0 || busy !== 4'h0 || ready !== 4'hF) begin
         mismatched++;
         $display("FAIL %s: line=%b done=%b busy=%b ready=%b want 1111 0000 0000 1111",
                  tag, line, done, busy, ready);
      end
   endtask

   typedef struct {
      int          unit;
      logic [31:0] word;
      logic        exp_par;
   } vec_t;

   vec_t tbl[5];
   logic p;

   initial begin
      tbl[0] = '{0, 32'hA5, 1'b1};
      tbl[1] = '{1, 32'h07, 1'b1};
      tbl[2] = '{1, 32'hA5, 1'b0};
      tbl[3] = '{2, 32'h00, 1'b1};
      tbl[4] = '{3, 32'h1F, 1'b0};

      rst   = 1'b1;
      valid = '0;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset_state");
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         send(tbl[i].unit, tbl[i].word, 1'b0, 32'h0, p);
         compared++;
         if (p !== tbl[i].exp_par) begin
            mismatched++;
            $display("FAIL parity_slot vec%0d: got %b want %b", i, p, tbl[i].exp_par);
         end
      end

      // Held valid with churning data: only the first word goes out, next accept right after done.
      send(0, 32'hA5, 1'b1, 32'h3C, p);
      check_frame(0, 32'h3C, 1'b0, 32'h0, p);

      // Reset mid-frame aborts and returns every unit to idle.
      @(negedge clk);
      valid[2] = 1'b1;
      d2       = 8'hF0;
      @(posedge clk);
      repeat (10) begin
         @(negedge clk);
         valid[2] = 1'b0;
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle("mid_frame_reset");
      end
      rst = 1'b0;
      @(negedge clk);
      check_idle("after_reset_release");

      for (int i = 0; i < 12; i++) begin
         send(int'($urandom_range(0, 3)), $urandom, 1'b0, 32'h0, p);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
